// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage between the ALU and writeback.
// Ports: clk/rst_n (sync active-low); in_* request from EX (valid/ready, store flag,
// funct3, address, store data, rd); mem_* single-outstanding data-memory port
// (req valid/ready, we, word addr, wstrb, lane-replicated wdata, rvalid, rdata);
// resp_* result to writeback (valid/ready, data, rd, err, cause).
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic [1:0]  resp_cause
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q, shifted, load_val;
    logic [2:0] funct3_q;
    logic accept, busy, timeout, illegal, misaligned, fault;
    assign accept = in_valid && in_ready;
    assign busy = state == S_REQ || state == S_WAIT;
    // Timeout wins over a coincident handshake or read response.
    assign timeout = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign illegal = in_is_store ? (in_funct3[2] || in_funct3[1:0] == 2'b11)
                                 : (in_funct3[1] && (in_funct3[0] || in_funct3[2]));
    assign misaligned = (in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                        (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
    assign fault = illegal || misaligned;
    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    assign load_val = funct3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                      funct3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
                      funct3_q == 3'b100 ? {24'd0, shifted[7:0]} :
                      funct3_q == 3'b101 ? {16'd0, shifted[15:0]} : shifted;
    assign in_ready = state == S_IDLE;
    assign mem_req_valid = state == S_REQ;
    assign resp_valid = state == S_RESP;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = in_valid ? (fault ? S_RESP : S_REQ) : S_IDLE;
            S_REQ:  state_nx = timeout ? S_RESP : mem_req_ready ? S_WAIT : S_REQ;
            S_WAIT: state_nx = (timeout || mem_rvalid) ? S_RESP : S_WAIT;
            S_RESP: state_nx = resp_ready ? S_IDLE : S_RESP;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= 1'b0;
            resp_cause <= '0;
        end else begin
            state <= state_nx;
            cnt   <= busy ? cnt + 1'b1 : '0;
            if (accept) begin
                addr_q     <= in_addr;
                funct3_q   <= in_funct3;
                mem_we     <= in_is_store;
                mem_addr   <= {in_addr[31:2], 2'b00};
                mem_wstrb  <= !in_is_store ? 4'b0000 :
                              in_funct3[1:0] == 2'b00 ? 4'b0001 << in_addr[1:0] :
                              in_funct3[1:0] == 2'b01 ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                mem_wdata  <= !in_is_store ? 32'd0 :
                              in_funct3[1:0] == 2'b00 ? {4{in_wdata[7:0]}} :
                              in_funct3[1:0] == 2'b01 ? {2{in_wdata[15:0]}} : in_wdata;
                resp_rd    <= in_rd;
                resp_err   <= fault;
                resp_cause <= illegal ? 2'd3 : misaligned ? 2'd1 : 2'd0;
                resp_data  <= fault ? in_addr : 32'd0;
            end
            if (timeout) begin
                resp_err   <= 1'b1;
                resp_cause <= 2'd2;
                resp_data  <= addr_q;
            end else if (state == S_WAIT && mem_rvalid && !mem_we) begin
                resp_data <= load_val;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level model
module tb_load_store_unit;
    localparam int TO = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_is_store = 1'b0, mem_req_ready = 1'b0, mem_rvalid = 1'b0, resp_ready = 1'b0;
    logic [2:0] in_funct3 = '0;
    logic [31:0] in_addr = '0, in_wdata = '0, mem_rdata = '0;
    logic [4:0] in_rd = '0;
    logic in_ready, mem_req_valid, mem_we, resp_valid, resp_err;
    logic [31:0] mem_addr, mem_wdata, resp_data;
    logic [3:0] mem_wstrb;
    logic [4:0] resp_rd;
    logic [1:0] resp_cause;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err), .resp_cause(resp_cause)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory port model: zero-wait, accepts requests immediately and answers one cycle later.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                           input logic [4:0] rd, output int lat, output logic saw, we,
                           output logic [31:0] maddr, mwdata, data, output logic [3:0] strb,
                           output logic err, output logic [1:0] cause, output logic [4:0] rrd);
        logic hs;
        hs = 1'b0;
        lat = -1; saw = 0; we = 0; maddr = 0; mwdata = 0; data = 0; strb = 0; err = 0; cause = 0; rrd = 0;
        in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
        tick;
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            mem_rvalid = hs;
            mem_rdata = rdat;
            if (resp_valid) begin
                lat = c; data = resp_data; err = resp_err; cause = resp_cause; rrd = resp_rd;
                break;
            end
            hs = mem_req_valid;
            if (mem_req_valid) begin
                saw = 1'b1; we = mem_we; maddr = mem_addr; mwdata = mem_wdata; strb = mem_wstrb;
            end
            tick;
        end
        mem_rvalid = 1'b0;
        mem_req_ready = 1'b0;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    // Reference: treats memory as four bytes and assembles/places them by access size.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                                  output logic err, output logic [1:0] cause, output logic [31:0] data,
                                  output logic [3:0] strb, output logic [31:0] wdat);
        int size, off;
        bit legal;
        longint v;
        size = 1 << f3[1:0];
        off = int'(a % 4);
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = 0; cause = 0; data = 0; strb = 0; wdat = 0; v = 0;
        if (!legal) begin
            err = 1; cause = 3; data = a;
            return;
        end
        if (a % size != 0) begin
            err = 1; cause = 1; data = a;
            return;
        end
        if (st) begin
            for (int i = 0; i < size; i++) strb[off + i] = 1'b1;
            for (int k = 0; k < 4; k++) wdat[8*k +: 8] = wd[8*(k % size) +: 8];
        end else begin
            for (int i = 0; i < size; i++) v = v | (longint'(rdat[8*(off + i) +: 8]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
            data = v[31:0];
        end
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if ({mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mem: got v=%b we=%b strb=%h a=%h d=%h expected all 0",
                               mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata);
        end
        checks++;
        if ({resp_valid, resp_err, resp_cause, resp_rd, resp_data} !== '0) begin
            errors++; $display("FAIL reset_resp: got v=%b err=%b c=%0d rd=%0d d=%h expected all 0",
                               resp_valid, resp_err, resp_cause, resp_rd, resp_data);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_directed;
        int lat;
        logic saw, we, err;
        logic [31:0] maddr, mwdata, data;
        logic [3:0] strb;
        logic [1:0] cause;
        logic [4:0] rrd;
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 5'd3, lat, saw, we, maddr, mwdata, data, strb, err, cause, rrd);
        checks++;
        if (lat !== 3 || !saw || we !== 1'b0 || strb !== 4'b0000 || maddr !== 32'h100) begin
            errors++; $display("FAIL lb_port: got lat=%0d saw=%b we=%b strb=%b addr=%h expected 3 1 0 0000 00000100", lat, saw, we, strb, maddr);
        end
        checks++;
        if (data !== 32'hFFFF_FF80 || err !== 1'b0 || rrd !== 5'd3) begin
            errors++; $display("FAIL lb_data: got d=%h err=%b rd=%0d expected ffffff80 0 3", data, err, rrd);
        end
        run_txn(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 5'd4, lat, saw, we, maddr, mwdata, data, strb, err, cause, rrd);
        checks++;
        if (lat !== 3 || we !== 1'b1 || mwdata !== 32'hBEEF_BEEF || strb !== 4'b1100 || maddr !== 32'h20) begin
            errors++; $display("FAIL sh_port: got lat=%0d we=%b wd=%h strb=%b addr=%h expected 3 1 beefbeef 1100 00000020", lat, we, mwdata, strb, maddr);
        end
        checks++;
        if (data !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sh_resp: got d=%h err=%b expected 0 0", data, err); end
        run_txn(1'b0, 3'b010, 32'h06, 32'h0, 32'h1234_5678, 5'd5, lat, saw, we, maddr, mwdata, data, strb, err, cause, rrd);
        checks++;
        if (lat !== 1 || saw !== 1'b0 || err !== 1'b1 || cause !== 2'd1 || data !== 32'h6 || rrd !== 5'd5) begin
            errors++; $display("FAIL lw_misaligned: got lat=%0d saw=%b err=%b c=%0d d=%h rd=%0d expected 1 0 1 1 00000006 5", lat, saw, err, cause, data, rrd);
        end
        run_txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd6, lat, saw, we, maddr, mwdata, data, strb, err, cause, rrd);
        checks++;
        if (lat !== 1 || saw !== 1'b0 || err !== 1'b1 || cause !== 2'd3 || data !== 32'h10) begin
            errors++; $display("FAIL illegal_f3: got lat=%0d saw=%b err=%b c=%0d d=%h expected 1 0 1 3 00000010", lat, saw, err, cause, data);
        end
    endtask

    task automatic test_random;
        int lat, elat;
        logic saw, we, err, eerr, st;
        logic [31:0] maddr, mwdata, data, edata, ewdat, a, wd, rdat;
        logic [3:0] strb, estrb;
        logic [1:0] cause, ecause;
        logic [4:0] rrd, rd;
        logic [2:0] f3;
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + 4 * $urandom_range(0, 1));
            if (f3 == 3'b110) f3 = 3'b010;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            rdat = $urandom;
            rd = 5'($urandom);
            model(st, f3, a, wd, rdat, eerr, ecause, edata, estrb, ewdat);
            elat = eerr ? 1 : 3;
            run_txn(st, f3, a, wd, rdat, rd, lat, saw, we, maddr, mwdata, data, strb, err, cause, rrd);
            checks++;
            if (lat !== elat || saw !== !eerr) begin
                errors++; $display("FAIL rand_lat[%0d]: got lat=%0d req=%b expected %0d %b", n, lat, saw, elat, !eerr);
            end
            checks++;
            if (data !== edata || err !== eerr || cause !== ecause || rrd !== rd) begin
                errors++; $display("FAIL rand_resp[%0d] st=%b f3=%0d a=%h: got d=%h err=%b c=%0d rd=%0d expected %h %b %0d %0d",
                                   n, st, f3, a, data, err, cause, rrd, edata, eerr, ecause, rd);
            end
            if (!eerr) begin
                checks++;
                if (we !== st || maddr !== {a[31:2], 2'b00} || strb !== estrb || (st && mwdata !== ewdat)) begin
                    errors++; $display("FAIL rand_port[%0d] st=%b f3=%0d a=%h: got we=%b addr=%h strb=%b wd=%h expected %b %h %b %h",
                                       n, st, f3, a, we, maddr, strb, mwdata, st, {a[31:2], 2'b00}, estrb, ewdat);
                end
            end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL back_to_back[%0d]: in_ready got %b expected 1", n, in_ready); end
        end
    endtask

    task automatic test_timeout;
        int lat;
        for (int m = 0; m < 2; m++) begin
            in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40; in_rd = 5'd9;
            tick;
            in_valid = 1'b0;
            mem_req_ready = 1'(m);
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                if (resp_valid) begin lat = c; break; end
                if (m == 0) begin
                    checks++;
                    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wstrb !== 4'b0) begin
                        errors++; $display("FAIL req_stable[%0d]: got v=%b addr=%h we=%b strb=%b expected 1 00000040 0 0000", c, mem_req_valid, mem_addr, mem_we, mem_wstrb);
                    end
                end
                tick;
                mem_req_ready = 1'b0;
            end
            checks++;
            if (lat !== TO + 1 || resp_err !== 1'b1 || resp_cause !== 2'd2 || resp_data !== 32'h40 || mem_req_valid !== 1'b0) begin
                errors++; $display("FAIL timeout[%0d]: got lat=%0d err=%b c=%0d d=%h req=%b expected %0d 1 2 00000040 0", m, lat, resp_err, resp_cause, resp_data, mem_req_valid, TO + 1);
            end
            mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            tick;
            mem_rvalid = 1'b0;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h40 || resp_cause !== 2'd2 || resp_rd !== 5'd9) begin
                errors++; $display("FAIL stray_rvalid[%0d]: got v=%b d=%h c=%0d rd=%0d expected 1 00000040 2 9", m, resp_valid, resp_data, resp_cause, resp_rd);
            end
            resp_ready = 1'b1;
            tick;
            resp_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_release[%0d]: got ready=%b v=%b expected 1 0", m, in_ready, resp_valid);
            end
        end
    endtask

    task automatic test_stall_reset;
        in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h2; in_rd = 5'd12;
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h2 || resp_cause !== 2'd1 || resp_err !== 1'b1 || resp_rd !== 5'd12) begin
                errors++; $display("FAIL resp_hold[%0d]: got v=%b d=%h c=%0d err=%b rd=%0d expected 1 00000002 1 1 12", c, resp_valid, resp_data, resp_cause, resp_err, resp_rd);
            end
            tick;
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (resp_valid !== 1'b0 || in_ready !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'h0) begin
            errors++; $display("FAIL reset_mid_resp: got v=%b ready=%b err=%b d=%h expected 0 1 0 0", resp_valid, in_ready, resp_err, resp_data);
        end
        rst_n = 1'b1;
        tick;
        in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b000; in_addr = 32'h81; in_wdata = 32'hA5;
        tick;
        in_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_wstrb !== 4'b0010 || mem_wdata !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL sb_pending: got v=%b strb=%b wd=%h expected 1 0010 a5a5a5a5", mem_req_valid, mem_wstrb, mem_wdata);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (mem_req_valid !== 1'b0 || in_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_req: got req=%b ready=%b v=%b expected 0 1 0", mem_req_valid, in_ready, resp_valid);
        end
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_timeout;
        test_stall_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
